// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the time-setting controller (package clock_pkg).
package clock_pkg;

    localparam int VALUE_W       = 6;
    localparam int MIN_SEC_LIMIT = 60;

    // Encoding doubles as the mode output: 0 run, 1 seconds, 2 minutes, 3 hours.
    typedef enum logic [1:0] {
        RUN = 2'd0,
        SEC = 2'd1,
        MIN = 2'd2,
        HR  = 2'd3
    } mode_t;

    function automatic logic [VALUE_W-1:0] field_max(mode_t m, int hours_limit);
        int lim;
        lim = (m == HR) ? hours_limit : MIN_SEC_LIMIT;
        return VALUE_W'(lim - 1);
    endfunction

    function automatic logic [VALUE_W-1:0] clamp_field(logic [VALUE_W-1:0] v, mode_t m,
                                                       int hours_limit);
        logic [VALUE_W-1:0] mx;
        mx = field_max(m, hours_limit);
        return (v > mx) ? mx : v;
    endfunction

endpackage

// File: rtl/time_set_ctrl_if.sv
// Counter-side bus of the time-setting controller: live counts and tick in, load/enable out.
interface time_set_ctrl_if;
    import clock_pkg::*;

    logic [VALUE_W-1:0] cur_sec;
    logic [VALUE_W-1:0] cur_min;
    logic [VALUE_W-1:0] cur_hr;
    logic               tick;
    logic               load;
    logic [1:0]         mode;
    logic [VALUE_W-1:0] value;
    logic               sec_en;

    modport master (
        input  cur_sec, cur_min, cur_hr, tick,
        output load, mode, value, sec_en
    );

    modport slave (
        output cur_sec, cur_min, cur_hr, tick,
        input  load, mode, value, sec_en
    );
endinterface

// File: rtl/time_set_ctrl_btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, optional debounce, rising-edge press pulse.
// Debounce is compiled in with TIME_SET_DEBOUNCE_EN.
module btn_conditioner #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Clr,
    input  logic btn,
    output logic press
);

    logic [1:0] sync;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) sync <= '0;
        else     sync <= {sync[0], btn};
    end

`ifdef TIME_SET_DEBOUNCE_EN
    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             level;
    logic [CNT_W-1:0] cnt;

    // level follows sync[1] only after the difference has persisted through the full count.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync[1] == level) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEBOUNCE_CYCLES)) begin
            level <= sync[1];
            cnt   <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign press = sync[1] & ~level & (cnt == CNT_W'(DEBOUNCE_CYCLES));
`else
    logic level_q;

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) level_q <= 1'b0;
        else     level_q <= sync[1];
    end

    assign press = sync[1] & ~level_q;
`endif

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller: cycles RUN/HR/MIN/SEC on btn_mode, edits the field with inc/dec.
// Define TIME_SET_DEBOUNCE_EN to add per-button debounce.
module time_set_ctrl
    import clock_pkg::*;
#(
    parameter int HOURS_LIMIT     = 24,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic Clk,
    input  logic Clr,
    input  logic btn_mode,
    input  logic btn_inc,
    input  logic btn_dec,
    time_set_ctrl_if.master bus
);

    logic mode_p, inc_p, dec_p;

    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode (
        .Clk(Clk), .Clr(Clr), .btn(btn_mode), .press(mode_p)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .Clk(Clk), .Clr(Clr), .btn(btn_inc), .press(inc_p)
    );
    btn_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dec (
        .Clk(Clk), .Clr(Clr), .btn(btn_dec), .press(dec_p)
    );

    mode_t              state, state_nxt;
    logic [VALUE_W-1:0] value, value_nxt;
    logic               load, load_nxt;
    logic [VALUE_W-1:0] fmax;

    assign fmax = field_max(state, HOURS_LIMIT);

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            state <= RUN;
            value <= '0;
            load  <= 1'b0;
        end else begin
            state <= state_nxt;
            value <= value_nxt;
            load  <= load_nxt;
        end
    end

    // A mode press pre-empts inc/dec; inc and dec together cancel out.
    always_comb begin
        state_nxt = state;
        value_nxt = value;
        load_nxt  = 1'b0;
        if (mode_p) begin
            unique case (state)
                RUN: begin
                    state_nxt = HR;
                    value_nxt = clamp_field(bus.cur_hr, HR, HOURS_LIMIT);
                end
                HR: begin
                    state_nxt = MIN;
                    value_nxt = clamp_field(bus.cur_min, MIN, HOURS_LIMIT);
                end
                MIN: begin
                    state_nxt = SEC;
                    value_nxt = clamp_field(bus.cur_sec, SEC, HOURS_LIMIT);
                end
                SEC: state_nxt = RUN;
            endcase
        end else if (state != RUN && (inc_p ^ dec_p)) begin
            load_nxt = 1'b1;
            if (inc_p) value_nxt = (value >= fmax) ? '0 : value + 1'b1;
            else       value_nxt = (value == '0) ? fmax : value - 1'b1;
        end
    end

    assign bus.load   = load;
    assign bus.mode   = state;
    assign bus.value  = value;
    assign bus.sec_en = bus.tick & (state == RUN) & ~Clr;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Scoreboard bench for time_set_ctrl: random button stimulus against a field-arithmetic model.
module tb_time_set_ctrl;

    localparam int HL = 24;
    localparam int DB = 16;
`ifdef TIME_SET_DEBOUNCE_EN
    localparam int LAT = 3 + DB;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        int cyc;
        int mode;
        int value;
    } ld_t;

    logic Clk      = 1'b0;
    logic Clr      = 1'b0;
    logic btn_mode = 1'b0;
    logic btn_inc  = 1'b0;
    logic btn_dec  = 1'b0;

    time_set_ctrl_if bus();

    time_set_ctrl #(.HOURS_LIMIT(HL), .DEBOUNCE_CYCLES(DB)) dut (
        .Clk      (Clk),
        .Clr      (Clr),
        .btn_mode (btn_mode),
        .btn_inc  (btn_inc),
        .btn_dec  (btn_dec),
        .bus      (bus)
    );

    initial forever #5 Clk = ~Clk;

    int  cyc = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  done = 1'b0;
    int  exp_mode = 0;
    int  exp_value = 0;
    ld_t sb[$];

    always @(posedge Clk) cyc++;

    initial begin
        bus.tick = 1'b0;
        forever begin
            @(posedge Clk);
            #2;
            bus.tick = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Monitor: continuous mode/value/sec_en checks, loads popped from the scoreboard.
    always @(negedge Clk) begin
        if (!done) begin
            ld_t e;
            check("mode", 32'(bus.mode), exp_mode);
            check("value", 32'(bus.value), exp_value);
            check("sec_en", 32'(bus.sec_en), 32'(bus.tick && exp_mode == 0 && !Clr));
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                check("load_pulse", 32'(bus.load), 1);
                check("load_mode", 32'(bus.mode), e.mode);
                check("load_value", 32'(bus.value), e.value);
            end else begin
                check("load_idle", 32'(bus.load), 0);
            end
        end
    end

    function automatic int limit_of(int m);
        return (m == 3) ? HL : 60;
    endfunction

    function automatic int cur_of(int m);
        case (m)
            3:       return int'(bus.cur_hr);
            2:       return int'(bus.cur_min);
            default: return int'(bus.cur_sec);
        endcase
    endfunction

    task automatic do_reset(int n);
        @(posedge Clk);
        #2;
        Clr = 1'b1;
        exp_mode  = 0;
        exp_value = 0;
        repeat (n) @(posedge Clk);
        #2;
        Clr = 1'b0;
    endtask

    task automatic press(bit m, bit i, bit d, int extra);
        int  dc;
        int  lim;
        ld_t e;
        @(posedge Clk);
        #2;
        btn_mode = m;
        btn_inc  = i;
        btn_dec  = d;
        dc = cyc;
        repeat (LAT) @(posedge Clk);
        #1;
        if (m) begin
            exp_mode = (exp_mode == 0) ? 3 : exp_mode - 1;
            if (exp_mode != 0) begin
                lim = limit_of(exp_mode);
                exp_value = (cur_of(exp_mode) >= lim) ? lim - 1 : cur_of(exp_mode);
            end
        end else if (exp_mode != 0 && i != d) begin
            lim = limit_of(exp_mode);
            exp_value = i ? (exp_value + 1) % lim : (exp_value + lim - 1) % lim;
            e.cyc = dc + LAT;
            e.mode = exp_mode;
            e.value = exp_value;
            sb.push_back(e);
        end
        repeat (extra) @(posedge Clk);
        #1;
        btn_mode = 1'b0;
        btn_inc  = 1'b0;
        btn_dec  = 1'b0;
        repeat (LAT + 2) @(posedge Clk);
    endtask

    initial begin
        bus.cur_sec = '0;
        bus.cur_min = '0;
        bus.cur_hr  = '0;
        do_reset(3);

        // Full mode cycle; sec_en only follows tick while in RUN.
        bus.cur_hr = 6'd5; bus.cur_min = 6'd30; bus.cur_sec = 6'd45;
        repeat (4) press(1'b1, 1'b0, 1'b0, 0);

        // Hours wrap 23 -> 0.
        bus.cur_hr = 6'd23;
        press(1'b1, 1'b0, 1'b0, 0);
        press(1'b0, 1'b1, 1'b0, 2);

        // Minutes wrap 0 -> 59.
        bus.cur_min = 6'd0;
        press(1'b1, 1'b0, 1'b0, 0);
        press(1'b0, 1'b0, 1'b1, 0);

        // Clear mid-SET_MIN aborts without a load.
        do_reset(2);
        repeat (3) @(posedge Clk);

        // Mode and inc together: mode wins, no load.
        bus.cur_hr = 6'd17;
        press(1'b1, 1'b1, 1'b0, 0);
        // inc and dec together cancel.
        press(1'b0, 1'b1, 1'b1, 0);
        // Long hold produces a single press.
        press(1'b0, 1'b0, 1'b1, 30);
        // Out-of-range capture clamps to 59.
        bus.cur_min = 6'd63;
        press(1'b1, 1'b0, 1'b0, 0);
        press(1'b0, 1'b1, 1'b0, 0);

`ifdef TIME_SET_DEBOUNCE_EN
        // Short glitch is rejected; a 20-cycle hold gives exactly one load.
        @(posedge Clk);
        #2;
        btn_inc = 1'b1;
        repeat (10) @(posedge Clk);
        #2;
        btn_inc = 1'b0;
        repeat (40) @(posedge Clk);
        press(1'b0, 1'b1, 1'b0, 1);
`endif

        // Out-of-range hours capture clamps to HL-1, then back down.
        do_reset(1);
        bus.cur_hr = 6'd40;
        press(1'b1, 1'b0, 1'b0, 0);
        press(1'b0, 1'b1, 1'b0, 0);
        press(1'b0, 1'b0, 1'b1, 0);
        press(1'b0, 1'b0, 1'b1, 0);

        for (int k = 0; k < 80; k++) begin
            bus.cur_sec = 6'($urandom_range(0, 63));
            bus.cur_min = 6'($urandom_range(0, 63));
            bus.cur_hr  = 6'($urandom_range(0, 63));
            if (k % 17 == 16) do_reset(1);
            press($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom), $urandom_range(0, 4));
        end

        repeat (3) @(posedge Clk);
        #1;
        done = 1'b1;
        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
